systolic_operand_loader: RTL
============================

Name: systolic_operand_loader

Overview:
- Upstream stage of the 4x4 systolic array controller.
- Accepts one frame of operands as a valid/ready word stream: N*N words of matrix A, then N*N words of matrix B, both row-major.
- Writes the words into the controller's A and B operand memories through its write ports, then drives the ap_start/ap_done handshake for one compute run.
- Does not accept the next frame until the run completes.

Parameters:
- N, 4, matrix dimension; a frame is 2*N*N words.
- DATA_W, 16, operand word width.
- ADDR_W, 16, write address width; must satisfy 2^ADDR_W >= N*N.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous active-high reset.
- s_valid  in  1  stream word valid.
- s_data  in  DATA_W  stream word.
- s_last  in  1  end-of-frame marker; legal only on word 2*N*N-1.
- s_ready  out  1  loader can accept a word.
- w_en_A  out  1  write strobe, A memory.
- write_addr_A  out  ADDR_W  A memory address.
- write_data_A  out  DATA_W  A memory data.
- w_en_B  out  1  write strobe, B memory.
- write_addr_B  out  ADDR_W  B memory address.
- write_data_B  out  DATA_W  B memory data.
- ap_start  out  1  compute request to controller (level).
- ap_done  in  1  compute complete from controller.
- busy  out  1  high in START or WAIT.
- frame_done  out  1  one-cycle pulse when a run completes.
- frame_err  out  1  sticky s_last position error.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to LOAD_A and the element counter to 0.
  - All outputs go to 0: s_ready, w_en_A/B, addresses, data, ap_start, busy, frame_done, frame_err.
  - s_ready rises in the first cycle after rst deasserts.
- Reset mid-operation abandons the frame; partially written memory contents are don't-care.
- A word is accepted when s_valid && s_ready at a rising edge.
- State machine:
  - LOAD_A: s_ready=1. Each accepted word is written to A at address = counter. Counter increments. After word N*N-1, the counter clears to 0 and the state goes to LOAD_B.
  - LOAD_B: s_ready=1. Same behaviour as LOAD_A, writing to B. After word N*N-1, the state goes to START.
  - START: s_ready=0; assert ap_start; go to WAIT.
  - WAIT: s_ready=0; ap_start stays 1 until ap_done is sampled high. In that cycle the state goes to LOAD_A and ap_start and busy register to 0 on the same edge. frame_done pulses high for the following cycle.
- Write timing:
  - All write outputs are registered.
  - For a word accepted at edge t, w_en, address and data are valid for exactly the cycle after t.
  - w_en is 0 whenever no word was accepted. Address and data hold their last values while w_en=0.
  - Only one of w_en_A or w_en_B is ever high in a cycle.
- Latency:
  - The final B write strobe is in cycle t+1.
  - ap_start first goes high in cycle t+2.
  - Minimum frame time is 2*N*N + 2 cycles plus the controller compute time.
- Back-to-back words with s_valid held high are accepted every cycle. Bubbles on s_valid just stall the counter.
- s_last checks:
  - s_last high on any word before 2*N*N-1: set frame_err, drop that word (no write), clear the counter, return to LOAD_A. No ap_start is issued.
  - s_last low on word 2*N*N-1: set frame_err. The frame is complete, so the run still starts.
- frame_err clears on the first word accepted in LOAD_A at counter 0, or on reset.
- ap_done outside WAIT is ignored.
- ap_done already high on entry to WAIT is accepted on the first WAIT cycle, so ap_start is high for exactly 1 cycle.
- Counter arithmetic: counter width is clog2(N*N). Its terminal value is N*N-1, with no wrap past it. Addresses are zero-extended to ADDR_W.

Test Plan:
- Nominal: reset, then stream 32 words 0x0001..0x0020 with s_valid held and s_last on word 31. Expect A addresses 0..15 written with 0x0001..0x0010 and B addresses 0..15 with 0x0011..0x0020, each strobe one cycle. ap_start rises 2 cycles after the last acceptance. s_ready=0 from then until the frame completes.
- Handshake: hold ap_done low for 10 cycles in WAIT, then pulse it for 1 cycle. Expect ap_start high for all 10+ cycles, low the cycle after ap_done, frame_done pulse, then s_ready=1.
- Stall: toggle s_valid every other cycle across a full frame. Expect identical memory contents to the nominal case, 16 strobes per matrix, and no duplicated addresses.
- Early s_last: set s_last on word 5 of A. Expect frame_err=1, no write for word 5, no ap_start. The next frame of 32 words loads A from address 0 and clears frame_err on its first word.
- Missing s_last: run 32 words with no s_last. Expect frame_err=1, all 32 writes, and ap_start still asserted.
- Reset mid-load: assert rst after 20 words. Expect all outputs 0 immediately (asynchronous). After release, a new 32-word frame loads A from address 0 and runs normally.

Source files
------------

// File: rtl/systolic_operand_loader.sv
// Frame loader for the 4x4 systolic array: streams A then B operands into the
// controller's operand memories, then runs one ap_start/ap_done handshake.
module systolic_operand_loader #(
    parameter int N      = 4,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic              w_en_A,
    output logic [ADDR_W-1:0] write_addr_A,
    output logic [DATA_W-1:0] write_data_A,
    output logic              w_en_B,
    output logic [ADDR_W-1:0] write_addr_B,
    output logic [DATA_W-1:0] write_data_B,
    output logic              ap_start,
    input  logic              ap_done,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_err
);

    localparam int ELEMS = N * N;
    localparam int CNT_W = (ELEMS > 1) ? $clog2(ELEMS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ELEMS - 1);

    typedef enum logic [1:0] {
        LOAD_A,
        LOAD_B,
        START,
        WAIT
    } state_t;

    state_t            stateReg;
    logic [CNT_W-1:0]  cntReg;
    logic              sReadyReg;
    logic              wEnAReg;
    logic              wEnBReg;
    logic [ADDR_W-1:0] addrAReg;
    logic [ADDR_W-1:0] addrBReg;
    logic [DATA_W-1:0] dataAReg;
    logic [DATA_W-1:0] dataBReg;
    logic              apStartReg;
    logic              busyReg;
    logic              frameDoneReg;
    logic              frameErrReg;

    logic accept;
    logic atLast;

    assign accept = s_valid && sReadyReg;
    assign atLast = (cntReg == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateReg     <= LOAD_A;
            cntReg       <= '0;
            sReadyReg    <= 1'b0;
            wEnAReg      <= 1'b0;
            wEnBReg      <= 1'b0;
            addrAReg     <= '0;
            addrBReg     <= '0;
            dataAReg     <= '0;
            dataBReg     <= '0;
            apStartReg   <= 1'b0;
            busyReg      <= 1'b0;
            frameDoneReg <= 1'b0;
            frameErrReg  <= 1'b0;
        end else begin
            wEnAReg      <= 1'b0;
            wEnBReg      <= 1'b0;
            frameDoneReg <= 1'b0;
            case (stateReg)
                LOAD_A: begin
                    sReadyReg <= 1'b1;
                    if (accept) begin
                        // Any s_last inside A is premature: drop the word and restart the frame.
                        if (s_last) begin
                            frameErrReg <= 1'b1;
                            cntReg      <= '0;
                        end else begin
                            if (cntReg == '0) begin
                                frameErrReg <= 1'b0;
                            end
                            wEnAReg  <= 1'b1;
                            addrAReg <= ADDR_W'(cntReg);
                            dataAReg <= s_data;
                            if (atLast) begin
                                cntReg   <= '0;
                                stateReg <= LOAD_B;
                            end else begin
                                cntReg <= cntReg + 1'b1;
                            end
                        end
                    end
                end
                LOAD_B: begin
                    sReadyReg <= 1'b1;
                    if (accept) begin
                        if (s_last && !atLast) begin
                            frameErrReg <= 1'b1;
                            cntReg      <= '0;
                            stateReg    <= LOAD_A;
                        end else begin
                            wEnBReg  <= 1'b1;
                            addrBReg <= ADDR_W'(cntReg);
                            dataBReg <= s_data;
                            if (atLast) begin
                                // A missing s_last is flagged, but the frame is whole so it still runs.
                                if (!s_last) begin
                                    frameErrReg <= 1'b1;
                                end
                                cntReg    <= '0;
                                sReadyReg <= 1'b0;
                                busyReg   <= 1'b1;
                                stateReg  <= START;
                            end else begin
                                cntReg <= cntReg + 1'b1;
                            end
                        end
                    end
                end
                START: begin
                    sReadyReg  <= 1'b0;
                    apStartReg <= 1'b1;
                    stateReg   <= WAIT;
                end
                WAIT: begin
                    if (ap_done) begin
                        apStartReg   <= 1'b0;
                        busyReg      <= 1'b0;
                        frameDoneReg <= 1'b1;
                        sReadyReg    <= 1'b1;
                        stateReg     <= LOAD_A;
                    end
                end
                default: begin
                    stateReg <= LOAD_A;
                end
            endcase
        end
    end

    assign s_ready      = sReadyReg;
    assign w_en_A       = wEnAReg;
    assign write_addr_A = addrAReg;
    assign write_data_A = dataAReg;
    assign w_en_B       = wEnBReg;
    assign write_addr_B = addrBReg;
    assign write_data_B = dataBReg;
    assign ap_start     = apStartReg;
    assign busy         = busyReg;
    assign frame_done   = frameDoneReg;
    assign frame_err    = frameErrReg;

endmodule
